moore_machine: RTL and testbench
================================

MOORE_MACHINE -- requirements
Module: moore_machine

Interface
REQ-001 Parameters: none; the detected pattern is fixed at 4'b1010.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-004 j  input  1  serial data bit; one bit consumed per rising clk edge.
REQ-005 w  output  1  detect flag; high while the FSM is in the detect state.

Function
REQ-006 The module SHALL be a Moore FSM that detects the serial pattern 1,0,1,0 (first bit earliest) on j, with overlap allowed.
REQ-007 Five states SHALL exist:
- S_IDLE: no useful prefix.
- S_1: seen "1".
- S_10: seen "10".
- S_101: seen "101".
- S_1010: pattern complete.
REQ-008 Transitions on each rising clk edge with rst_n=1, written j=0 / j=1:
- S_IDLE -> S_IDLE / S_1.
- S_1 -> S_10 / S_1.
- S_10 -> S_IDLE / S_101.
- S_101 -> S_1010 / S_1.
- S_1010 -> S_IDLE / S_101 (overlap: trailing "10" is reused).
REQ-009 w SHALL depend only on the registered state: w=1 iff state==S_1010, else w=0; no combinational path from j to w.
REQ-010 Latency: w SHALL rise in the clock cycle immediately after the edge that samples the final 0 of the pattern, and SHALL stay high for exactly one cycle per detection.
REQ-011 Back-to-back overlapping matches SHALL produce pulses two cycles apart (input 101010 gives w high after the 4th and 6th bits).
REQ-012 j SHALL be sampled only at rising clk edges; changes between edges SHALL have no effect.
REQ-013 An X on j after reset is out of contract; the bench SHALL drive 0/1 only.

Reset
REQ-014 When rst_n=0 at a rising clk edge, state SHALL become S_IDLE regardless of j or the current state.
REQ-015 Reset value of w SHALL be 0.
REQ-016 Reset asserted mid-pattern SHALL discard the partial match; detection restarts from the next edge with rst_n=1.
REQ-017 Before the first reset edge, state and w are undefined; the bench SHALL apply reset first.

Structure
REQ-018 The state enum type and the PATTERN constant (4'b1010) SHALL live in a shared package, moore_machine_pkg.
REQ-019 The module SHALL be a single module with a state register and a separate next-state/output decode.
- No sub-module is required.
- An optional leaf moore_machine_next_state (pure combinational next-state function) is permitted.
REQ-020 Unreachable or illegal state encodings SHALL return to S_IDLE on the next edge.

Verification
REQ-021 Reset: hold rst_n=0 for 2 edges with j=1 -> state S_IDLE and w=0 after each edge.
REQ-022 Mixed stream: j=1,1,0,0,1,0,1,0,1,1,0 -> states S_1,S_1,S_10,S_IDLE,S_1,S_10,S_101,S_1010,S_101,S_1,S_10, with w=1 only after the 8th bit.
REQ-023 Overlap: j=1,0,1,0,1,0 -> w=1 after the 4th and 6th bits only; w=0 otherwise.
REQ-024 Reset mid-pattern: j=1,0,1 then rst_n=0 for one edge, then j=0 -> w stays 0 throughout.
REQ-025 No false match: j=1,1,1,1 then 0,0,0,0 -> w=0 at every edge.
REQ-026 Glitch immunity: toggle j between clk edges with a stable value at each edge -> response matches that of the sampled values only.

Source files
------------

// File: rtl/moore_machine_pkg.sv
// Shared types and constants for the 1010 serial pattern detector.
package moore_machine_pkg;

    // Serial pattern detected by the FSM, first bit earliest in bit 3.
    localparam logic [3:0] PATTERN = 4'b1010;

    // Each state names the longest useful prefix of PATTERN seen so far.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1010 = 3'd4
    } state_t;

endpackage

// File: rtl/moore_machine_next_state.sv
// Pure combinational next-state function of the 1010 detector.
module moore_machine_next_state
    import moore_machine_pkg::*;
(
    input  state_t state_i,
    input  logic   j_i,
    output state_t state_o
);

    // Overlapping detection: after a full match the trailing "10" is kept, so
    // a following 1 lands in S_101. Illegal encodings fall back to S_IDLE.
    always_comb begin
        state_o = S_IDLE;
        case (state_i)
            S_IDLE:  state_o = j_i ? S_1   : S_IDLE;
            S_1:     state_o = j_i ? S_1   : S_10;
            S_10:    state_o = j_i ? S_101 : S_IDLE;
            S_101:   state_o = j_i ? S_1   : S_1010;
            S_1010:  state_o = j_i ? S_101 : S_IDLE;
            default: state_o = S_IDLE;
        endcase
    end

endmodule

// File: rtl/moore_machine.sv
// Moore FSM detecting the serial pattern 1,0,1,0 on j with overlap.
// w is a registered flag that is high exactly while the FSM sits in S_1010.
module moore_machine
    import moore_machine_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    output logic w
);

    state_t state_q;
    state_t state_d;
    logic   w_q;

    moore_machine_next_state u_next_state (
        .state_i (state_q),
        .j_i     (j),
        .state_o (state_d)
    );

    // State register and registered detect flag; w_q always mirrors
    // (state_q == S_1010), so there is no combinational path from j to w.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= (state_d == S_1010);
        end
    end

    assign w = w_q;

endmodule

// File: tb/tb_moore_machine.sv
// Self-checking bench for moore_machine: directed sequences plus a random
// stream, checked against a sliding-window model of the last four bits.
module tb_moore_machine;
    import moore_machine_pkg::*;

    logic clk;
    logic rst_n;
    logic j;
    logic w;

    int checks;
    int errors;

    // Reference model: bits seen since the last reset, newest in bit 0.
    logic [3:0] hist;
    int         nbits;
    logic       exp_w;

    moore_machine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (j),
        .w     (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one bit (or reset) for one rising edge, optionally toggling j
    // between edges, then compare w against the model just after the edge.
    task automatic step(input logic rv, input logic jv, input logic glitch,
                        input string tag);
        @(negedge clk);
        rst_n = rv;
        j     = jv;
        if (glitch) begin
            #1 j = ~jv;
            #1 j = jv;
            #1 j = ~jv;
            #1 j = jv;
        end
        // model update for this edge
        if (!rv) begin
            nbits = 0;
            hist  = 4'b0000;
        end else begin
            hist  = {hist[2:0], jv};
            nbits = nbits + 1;
        end
        exp_w = rv && (nbits >= 4) && (hist == PATTERN);
        @(posedge clk);
        #1;
        checks++;
        assert (w === exp_w)
        else begin
            errors++;
            $error("FAIL %s: w=%0b expected %0b (j=%0b rst_n=%0b)", tag, w, exp_w, jv, rv);
        end
        if (glitch) begin
            #1 j = ~jv;
            #1 j = jv;
        end
    endtask

    initial begin
        logic [10:0] mixed;
        logic [5:0]  ovl;
        checks = 0;
        errors = 0;
        hist   = 4'b0000;
        nbits  = 0;
        exp_w  = 1'b0;
        rst_n  = 1'b0;
        j      = 1'b1;

        // Reset held for two edges with j=1
        step(1'b0, 1'b1, 1'b0, "reset0");
        step(1'b0, 1'b1, 1'b0, "reset1");

        // Mixed stream 1,1,0,0,1,0,1,0,1,1,0 (w only after the 8th bit)
        mixed = 11'b11001010110;
        for (int i = 10; i >= 0; i--) step(1'b1, mixed[i], 1'b0, "mixed");

        // Overlap 1,0,1,0,1,0 after a clean reset
        step(1'b0, 1'b0, 1'b0, "ovl_rst");
        ovl = 6'b101010;
        for (int i = 5; i >= 0; i--) step(1'b1, ovl[i], 1'b0, "overlap");

        // Reset mid-pattern discards the partial 101
        step(1'b0, 1'b0, 1'b0, "mid_rst0");
        step(1'b1, 1'b1, 1'b0, "mid_a");
        step(1'b1, 1'b0, 1'b0, "mid_b");
        step(1'b1, 1'b1, 1'b0, "mid_c");
        step(1'b0, 1'b0, 1'b0, "mid_rst");
        step(1'b1, 1'b0, 1'b0, "mid_after");
        step(1'b1, 1'b1, 1'b0, "mid_after2");

        // No false match: 1111 then 0000
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, "nofalse1");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "nofalse0");

        // Glitch immunity: overlapping pattern with j toggling between edges
        for (int i = 5; i >= 0; i--) step(1'b1, ovl[i], 1'b1, "glitch");
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, "glitch_rnd");

        // Random stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, "rnd_rst");
            else
                step(1'b1, 1'($urandom_range(0, 1)), 1'b0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
